// File: rtl/ovf_mon_if.sv
// Bus between the overflow monitor and its environment: upstream counter status in,
// counter re-arm pulse, event count, interrupt handshake and captured values out.
interface ovf_mon_if #(
    parameter int CNT_WIDTH = 4,
    parameter int EVT_WIDTH = 8
);
    logic [CNT_WIDTH-1:0] counter_in;
    logic                 overflow_in;
    logic                 clear_req;
    logic                 irq_ack;
    logic                 counter_clear;
    logic [EVT_WIDTH-1:0] event_count;
    logic                 irq;
    logic [CNT_WIDTH-1:0] snapshot;
    logic [15:0]          last_event_ts;

    modport master (
        output counter_in, overflow_in, clear_req, irq_ack,
        input  counter_clear, event_count, irq, snapshot, last_event_ts
    );

    modport slave (
        input  counter_in, overflow_in, clear_req, irq_ack,
        output counter_clear, event_count, irq, snapshot, last_event_ts
    );
endinterface

// File: rtl/overflow_monitor.sv
// Overflow monitor: counts rising edges of the upstream sticky overflow flag, pulses a
// counter re-arm, raises a one-shot irq at THRESHOLD. Macro OVF_MONITOR_TIMESTAMP_EN adds event timestamps.
module overflow_monitor #(
    parameter int CNT_WIDTH = 4,
    parameter int EVT_WIDTH = 8,
    parameter int THRESHOLD = 3
) (
    input  logic     clk,
    input  logic     reset,
    ovf_mon_if.slave bus
);

    typedef enum logic {IDLE, CLR} state_e;

    localparam logic [EVT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [EVT_WIDTH-1:0] THR     = EVT_WIDTH'(THRESHOLD);

    state_e               state_q, state_d;
    logic                 ovf_q, ovf_d;
    logic                 clr_q, clr_d;
    logic [EVT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 irq_q, irq_d;
    logic                 armed_q, armed_d;
    logic [CNT_WIDTH-1:0] snap_q, snap_d;

    logic                 evt;
    logic                 inc;
    logic                 fire;
    logic [EVT_WIDTH-1:0] cnt_base;
    logic                 armed_base;

    always_comb begin
        // The flag stays high while upstream is being cleared; ovf_q masks it in CLR.
        evt        = bus.overflow_in && !ovf_q && (state_q == IDLE);
        ovf_d      = bus.overflow_in;

        // clear_req is applied first, then a coincident event increments from zero.
        cnt_base   = bus.clear_req ? '0   : cnt_q;
        armed_base = bus.clear_req ? 1'b1 : armed_q;
        snap_d     = bus.clear_req ? bus.counter_in : snap_q;

        inc        = evt && (cnt_base != CNT_MAX);
        cnt_d      = inc ? cnt_base + 1'b1 : cnt_base;
        fire       = inc && ((cnt_base + 1'b1) == THR) && armed_base;
        armed_d    = fire ? 1'b0 : armed_base;
        irq_d      = fire || (irq_q && !bus.irq_ack);

        state_d    = IDLE;
        case (state_q)
            IDLE:    state_d = evt ? CLR : IDLE;
            CLR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        clr_d      = (state_d == CLR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ovf_q   <= 1'b0;
            clr_q   <= 1'b0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            armed_q <= 1'b1;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            armed_q <= armed_d;
            snap_q  <= snap_d;
        end
    end

    assign bus.counter_clear = clr_q;
    assign bus.event_count   = cnt_q;
    assign bus.irq           = irq_q;
    assign bus.snapshot      = snap_q;

`ifdef OVF_MONITOR_TIMESTAMP_EN
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] ts_q, ts_d;

    always_comb begin
        cyc_d = cyc_q + 16'd1;
        ts_d  = evt ? cyc_q : ts_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
            ts_q  <= '0;
        end else begin
            cyc_q <= cyc_d;
            ts_q  <= ts_d;
        end
    end

    assign bus.last_event_ts = ts_q;
`else
    assign bus.last_event_ts = 16'h0000;
`endif

endmodule

// File: tb/tb_overflow_monitor.sv
// Directed + random bench for overflow_monitor; two instances (EVT_WIDTH 8 and 2) share stimulus.
module tb_overflow_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cin = '0;
    logic       ovf = 1'b0;
    logic       clr = 1'b0;
    logic       ack = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: counts as integers, flags as bits.
    int         m_cnt, m_cnt2;
    bit         m_arm, m_arm2, m_irq, m_irq2;
    bit         m_ovf_prev, m_in_clr;
    logic [3:0] m_snap;
    logic [15:0] m_cyc, m_ts;

    always #5 clk = ~clk;

    ovf_mon_if #(.CNT_WIDTH(4), .EVT_WIDTH(8)) bus8 ();
    ovf_mon_if #(.CNT_WIDTH(4), .EVT_WIDTH(2)) bus2 ();

    assign bus8.counter_in  = cin;
    assign bus8.overflow_in = ovf;
    assign bus8.clear_req   = clr;
    assign bus8.irq_ack     = ack;
    assign bus2.counter_in  = cin;
    assign bus2.overflow_in = ovf;
    assign bus2.clear_req   = clr;
    assign bus2.irq_ack     = ack;

    overflow_monitor #(.CNT_WIDTH(4), .EVT_WIDTH(8), .THRESHOLD(3)) dut8 (
        .clk(clk), .reset(rst_n), .bus(bus8));
    overflow_monitor #(.CNT_WIDTH(4), .EVT_WIDTH(2), .THRESHOLD(3)) dut2 (
        .clk(clk), .reset(rst_n), .bus(bus2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_cnt2 = 0;
        m_arm = 1; m_arm2 = 1;
        m_irq = 0; m_irq2 = 0;
        m_ovf_prev = 0; m_in_clr = 0;
        m_snap = '0; m_cyc = '0; m_ts = '0;
    endtask

    task automatic upd(inout int c, inout bit a, inout bit q, input int maxv, input bit evt);
        if (q && ack) q = 0;
        if (clr) begin c = 0; a = 1; end
        if (evt && c < maxv) begin
            c++;
            if (c == 3 && a) begin q = 1; a = 0; end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " clear8"}, 32'(bus8.counter_clear), 32'(m_in_clr));
        chk({tag, " cnt8"},   32'(bus8.event_count),   32'(m_cnt));
        chk({tag, " irq8"},   32'(bus8.irq),           32'(m_irq));
        chk({tag, " snap8"},  32'(bus8.snapshot),      32'(m_snap));
`ifdef OVF_MONITOR_TIMESTAMP_EN
        chk({tag, " ts8"},    32'(bus8.last_event_ts), 32'(m_ts));
`else
        chk({tag, " ts8"},    32'(bus8.last_event_ts), 32'h0);
`endif
        chk({tag, " clear2"}, 32'(bus2.counter_clear), 32'(m_in_clr));
        chk({tag, " cnt2"},   32'(bus2.event_count),   32'(m_cnt2));
        chk({tag, " irq2"},   32'(bus2.irq),           32'(m_irq2));
    endtask

    // One clock: advance the reference at the edge, then compare 1 time unit later.
    task automatic cyc();
        bit evt;
        @(posedge clk);
        evt = ovf && !m_ovf_prev && !m_in_clr;
        upd(m_cnt,  m_arm,  m_irq,  255, evt);
        upd(m_cnt2, m_arm2, m_irq2, 3,   evt);
        if (clr) m_snap = cin;
        if (evt) m_ts = m_cyc;
        m_cyc      = m_cyc + 16'd1;
        m_ovf_prev = ovf;
        m_in_clr   = evt;
        #1 check_all("cyc");
    endtask

    task automatic ev();
        ovf = 1; cyc();
        ovf = 0; cyc(); cyc();
    endtask

    // Pulse reset between clock edges to exercise the asynchronous path.
    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("rst clear", 32'(bus8.counter_clear), 32'h0);
        chk("rst irq",   32'(bus8.irq),           32'h0);
        chk("rst cnt",   32'(bus8.event_count),   32'h0);
        #1 rst_n = 1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        chk("reset cnt", 32'(bus8.event_count), 32'h0);
        #1 rst_n = 1;

        // Held flag counts once; re-arm pulse only in the first cycle.
        ovf = 1; cyc();
        chk("hold clear", 32'(bus8.counter_clear), 32'h1);
        chk("hold cnt",   32'(bus8.event_count),   32'h1);
        repeat (4) cyc();
        chk("hold clear_end", 32'(bus8.counter_clear), 32'h0);
        chk("hold cnt_end",   32'(bus8.event_count),   32'h1);
        ovf = 0; cyc();

        // Threshold, acknowledge, no re-fire.
        ev(); ev();
        chk("thr irq", 32'(bus8.irq), 32'h1);
        cyc(); cyc();
        ack = 1; cyc(); ack = 0;
        chk("ack irq", 32'(bus8.irq), 32'h0);
        ev();
        chk("4th irq", 32'(bus8.irq),         32'h0);
        chk("4th cnt", 32'(bus8.event_count), 32'h4);

        // Up to 7, narrow instance saturates.
        ev(); ev(); ev();
        chk("cnt7", 32'(bus8.event_count), 32'h7);
        chk("sat2", 32'(bus2.event_count), 32'h3);
        chk("sat2 irq", 32'(bus2.irq), 32'h0);

        // Clear coincident with event.
        clr = 1; ovf = 1; cyc(); clr = 0; ovf = 0;
        chk("clr+evt cnt", 32'(bus8.event_count), 32'h1);
        cyc(); cyc();

        // Clear alone captures snapshot and re-arms.
        cin = 4'hA; clr = 1; cyc(); clr = 0;
        chk("clr cnt",  32'(bus8.event_count), 32'h0);
        chk("clr snap", 32'(bus8.snapshot),    32'hA);
        ev(); ev(); ev();
        chk("refire irq", 32'(bus8.irq), 32'h1);

        // Async reset with irq high, then count restarts at 1.
        do_reset();
        ev();
        chk("post-rst cnt", 32'(bus8.event_count), 32'h1);

        // Reset while in CLR.
        ovf = 1; cyc();
        chk("midclr clear", 32'(bus8.counter_clear), 32'h1);
        ovf = 0;
        do_reset();
        cyc(); cyc();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ovf = ($urandom_range(0, 9) < 4);
            clr = ($urandom_range(0, 15) == 0);
            ack = ($urandom_range(0, 3) == 0);
            cin = 4'($urandom);
            cyc();
        end
        clr = 0; ack = 0; ovf = 0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
